// File: rtl/multdiv_unit_if.sv
// Handshake and operand/result bundle shared by the multiply/divide unit and its requester.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (Booth) / restoring divide with a one-cycle result-ready pulse.
// Define MULTDIV_FAST_MULT_EN for radix-4 Booth multiply (half the multiply iterations).
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          clr,
  multdiv_unit_if.slave bus
);
  localparam int AW = WIDTH + 2;
`ifdef MULTDIV_FAST_MULT_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / 2);
`else
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH);
`endif
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [AW-1:0]    acc_reg, acc_next, opd_reg, opd_next;
  logic [WIDTH-1:0] lo_reg, lo_next, res_reg, res_next;
  logic             qm1_reg, qm1_next, neg_reg, neg_next;
  logic             bz_reg, bz_next, dexc_reg, dexc_next, exc_reg, exc_next;

  // Magnitudes kept unsigned in WIDTH bits: |most-negative| = 2^(WIDTH-1) still fits.
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             a_is_min, b_is_m1;
  assign mag_a    = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b    = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
  assign a_is_min = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}});
  assign b_is_m1  = &bus.data_operandB;

  // Accumulator has two guard bits so that adding +-2A never wraps.
  logic [AW-1:0]    booth_add, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_lo;
  logic             booth_qm1;
`ifdef MULTDIV_FAST_MULT_EN
  always_comb begin
    case ({lo_reg[1:0], qm1_reg})
      3'b001, 3'b010: booth_add = opd_reg;
      3'b011:         booth_add = opd_reg << 1;
      3'b100:         booth_add = -(opd_reg << 1);
      3'b101, 3'b110: booth_add = -opd_reg;
      default:        booth_add = '0;
    endcase
  end
  assign booth_sum = acc_reg + booth_add;
  assign booth_acc = {{2{booth_sum[AW-1]}}, booth_sum[AW-1:2]};
  assign booth_lo  = {booth_sum[1:0], lo_reg[WIDTH-1:2]};
  assign booth_qm1 = lo_reg[1];
`else
  always_comb begin
    case ({lo_reg[0], qm1_reg})
      2'b01:   booth_add = opd_reg;
      2'b10:   booth_add = -opd_reg;
      default: booth_add = '0;
    endcase
  end
  assign booth_sum = acc_reg + booth_add;
  assign booth_acc = {booth_sum[AW-1], booth_sum[AW-1:1]};
  assign booth_lo  = {booth_sum[0], lo_reg[WIDTH-1:1]};
  assign booth_qm1 = lo_reg[0];
`endif

  logic [AW-1:0] div_shift, div_trial;
  logic [WIDTH:0] mul_hi;
  logic           mul_ovf;
  assign div_shift = {acc_reg[WIDTH:0], lo_reg[WIDTH-1]};
  assign div_trial = div_shift - opd_reg;
  assign mul_hi    = {acc_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
  assign mul_ovf   = !((&mul_hi) || (~|mul_hi));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    acc_next   = acc_reg;
    opd_next   = opd_reg;
    lo_next    = lo_reg;
    qm1_next   = qm1_reg;
    neg_next   = neg_reg;
    bz_next    = bz_reg;
    dexc_next  = dexc_reg;
    res_next   = res_reg;
    exc_next   = exc_reg;
    if (bus.ctrl_MULT) begin
      state_next = S_MUL;
      cnt_next   = '0;
      acc_next   = '0;
      opd_next   = {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
      lo_next    = bus.data_operandB;
      qm1_next   = 1'b0;
    end else if (bus.ctrl_DIV) begin
      state_next = S_DIV;
      cnt_next   = '0;
      acc_next   = '0;
      opd_next   = {2'b00, mag_b};
      lo_next    = mag_a;
      neg_next   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      bz_next    = (bus.data_operandB == '0);
      dexc_next  = (bus.data_operandB == '0) || (a_is_min && b_is_m1);
    end else begin
      case (state_reg)
        S_MUL: begin
          if (cnt_reg == MUL_LAST) begin
            res_next   = lo_reg;
            exc_next   = mul_ovf;
            state_next = S_DONE;
          end else begin
            acc_next = booth_acc;
            lo_next  = booth_lo;
            qm1_next = booth_qm1;
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (cnt_reg == DIV_LAST) begin
            res_next   = bz_reg ? '0 : (neg_reg ? -lo_reg : lo_reg);
            exc_next   = dexc_reg;
            state_next = S_DONE;
          end else begin
            if (!div_trial[AW-1]) begin
              acc_next = div_trial;
              lo_next  = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
              acc_next = div_shift;
              lo_next  = {lo_reg[WIDTH-2:0], 1'b0};
            end
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      opd_reg   <= '0;
      lo_reg    <= '0;
      qm1_reg   <= 1'b0;
      neg_reg   <= 1'b0;
      bz_reg    <= 1'b0;
      dexc_reg  <= 1'b0;
      res_reg   <= '0;
      exc_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      opd_reg   <= opd_next;
      lo_reg    <= lo_next;
      qm1_reg   <= qm1_next;
      neg_reg   <= neg_next;
      bz_reg    <= bz_next;
      dexc_reg  <= dexc_next;
      res_reg   <= res_next;
      exc_reg   <= exc_next;
    end
  end

  assign bus.data_result    = res_reg;
  assign bus.data_exception = exc_reg;
  assign bus.data_resultRDY = (state_reg == S_DONE);
endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: directed vectors, monitor checks value, flag and RDY cycle.
module tb_multdiv_unit;
  localparam int W = 32;
`ifdef MULTDIV_FAST_MULT_EN
  localparam int MUL_LAT = W / 2;
`else
  localparam int MUL_LAT = W;
`endif
  localparam int DIV_LAT = W;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  multdiv_unit_if #(.WIDTH(W)) bus ();
  multdiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .clr(clr), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every RDY pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rdy cyc=%0d result=%h", cyc, bus.data_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total += 3;
        if (cyc != e.cyc) begin
          bad++; $display("FAIL rdy_cycle got=%0d want=%0d", cyc, e.cyc);
        end
        if (bus.data_result !== e.res) begin
          bad++; $display("FAIL result got=%h want=%h", bus.data_result, e.res);
        end
        if (bus.data_exception !== e.exc) begin
          bad++; $display("FAIL exception got=%b want=%b", bus.data_exception, e.exc);
        end
        $display("txn cyc=%0d result=%h exc=%b", cyc, bus.data_result, bus.data_exception);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] er, input bit ee);
    @(negedge clk);
    bus.ctrl_MULT = m;
    bus.ctrl_DIV = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    if (push) sb.push_back('{er, ee, cyc + (m ? MUL_LAT : DIV_LAT) + 1});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d want=0", sb.size());
      sb.delete();
    end
    idle(2);
  endtask

  task automatic check_outs(input string name);
    total += 3;
    if (bus.data_result !== '0) begin
      bad++; $display("FAIL %s_result got=%h want=0", name, bus.data_result);
    end
    if (bus.data_exception !== 1'b0) begin
      bad++; $display("FAIL %s_exception got=%b want=0", name, bus.data_exception);
    end
    if (bus.data_resultRDY !== 1'b0) begin
      bad++; $display("FAIL %s_rdy got=%b want=0", name, bus.data_resultRDY);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    clr = 1'b0;

    start(1, 0, 32'd7, -32'sd3, 1, 32'hFFFF_FFEB, 0);            drain();
    start(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0, 1);      drain();
    start(1, 0, 32'h8000_0000, 32'd1, 1, 32'h8000_0000, 0);      drain();
    start(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd1, 0);      drain();
    start(1, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 32'd1, 1);      drain();
    start(0, 1, -32'sd100, 32'd7, 1, 32'hFFFF_FFF2, 0);          drain();
    start(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1); drain();
    start(0, 1, 32'd7, -32'sd2, 1, 32'hFFFF_FFFD, 0);            drain();
    start(0, 1, 32'd5, 32'd0, 1, 32'h0, 1);                      drain();
    start(0, 1, 32'd0, 32'd9, 1, 32'h0, 0);                      drain();

    // Multiply aborted at t+10 by a divide: only the divide reports.
    start(1, 0, 32'd3, 32'd4, 0, 32'h0, 0);
    idle(9);
    start(0, 1, 32'd40, 32'd5, 1, 32'd8, 0);                     drain();
    start(1, 1, 32'd6, 32'd2, 1, 32'd12, 0);                     drain();

    // Divide abandoned by clr at t+20; nothing may report afterwards.
    start(0, 1, 32'd1000, 32'd3, 0, 32'h0, 0);
    idle(19);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_outs("clr_mid");
    clr = 1'b0;
    idle(25);
    start(1, 0, 32'd2, 32'd2, 1, 32'd4, 0);                      drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
